// File: rtl/generador_patrones_pkg.sv
// Shared encodings for the pattern generator: pattern modes and FSM states.
package paquete_patrones;

  localparam int unsigned MODO_W   = 2;
  localparam int unsigned ESTADO_W = 2;
  localparam int unsigned CUENTA_W = 16;

  localparam logic [MODO_W-1:0] MODO_CONST = 2'b00;
  localparam logic [MODO_W-1:0] MODO_RAMPA = 2'b01;
  localparam logic [MODO_W-1:0] MODO_UNO   = 2'b10;
  localparam logic [MODO_W-1:0] MODO_LFSR  = 2'b11;

  typedef enum logic [ESTADO_W-1:0] {
    REPOSO = 2'd0,
    CEBADO = 2'd1,
    ACTIVO = 2'd2
  } estado_t;

endpackage

// File: rtl/generador_patrones_if.sv
// Control, handshake and data bundle between the pattern source and its consumer.
interface generador_patrones_if
  import paquete_patrones::*;
#(
  parameter int unsigned ANCHO   = 16,
  parameter int unsigned CANALES = 2
) ();

  logic                       habilitar;
  logic [MODO_W-1:0]          modo;
  logic                       cargar;
  logic [ANCHO-1:0]           valor_carga;
  logic                       listo;
  logic                       valido;
  logic [CANALES*ANCHO-1:0]   respuesta;
  logic [CUENTA_W-1:0]        cuenta_beats;

  // Generator side
  modport master (
    input  habilitar, modo, cargar, valor_carga, listo,
    output valido, respuesta, cuenta_beats
  );

  // Consumer / controller side
  modport slave (
    output habilitar, modo, cargar, valor_carga, listo,
    input  valido, respuesta, cuenta_beats
  );

endinterface

// File: rtl/generador_patrones_paso_patron.sv
// Next base word for the selected pattern mode (pure combinational step).
module paso_patron
  import paquete_patrones::*;
#(
  parameter int unsigned      ANCHO     = 16,
  parameter logic [ANCHO-1:0] CONSTANTE = '0,
  parameter logic [ANCHO-1:0] TOMAS     = ANCHO'(16'hB400)
) (
  input  logic [MODO_W-1:0] modo,
  input  logic [ANCHO-1:0]  w,
  output logic [ANCHO-1:0]  siguiente_c
);

  // One step of constant / ramp / rotate-left / Galois LFSR
  always_comb begin
    siguiente_c = w;
    unique case (modo)
      MODO_CONST: siguiente_c = CONSTANTE;
      MODO_RAMPA: siguiente_c = w + ANCHO'(1);
      MODO_UNO:   siguiente_c = {w[ANCHO-2:0], w[ANCHO-1]};
      MODO_LFSR:  siguiente_c = (w >> 1) ^ (w[0] ? TOMAS : '0);
      default:    siguiente_c = w;
    endcase
  end

endmodule

// File: rtl/generador_patrones.sv
// Parametrised multi-channel test-pattern source with valid/ready output.
module generador_patrones
  import paquete_patrones::*;
#(
  parameter int unsigned      ANCHO     = 16,
  parameter int unsigned      CANALES   = 2,
  parameter logic [ANCHO-1:0] CONSTANTE = '0,
  parameter logic [ANCHO-1:0] SEMILLA   = ANCHO'(16'hACE1),
  parameter logic [ANCHO-1:0] TOMAS     = ANCHO'(16'hB400)
) (
  input logic                  Reloj,
  input logic                  Reinicio,
  generador_patrones_if.master bus
);

  localparam int unsigned RESP_W = CANALES * ANCHO;
  localparam logic [CUENTA_W-1:0] CUENTA_MAX = '1;
  // Non-zero substitute so the LFSR never starts locked at zero
  localparam logic [ANCHO-1:0] SEMILLA_LFSR = (SEMILLA == '0) ? ANCHO'(1) : SEMILLA;

  estado_t              estado;
  logic [MODO_W-1:0]    modo_reg;
  logic [ANCHO-1:0]     base;
  logic [CUENTA_W-1:0]  cuenta_q;
  logic                 valido_q;
  logic [RESP_W-1:0]    resp_q;

  logic [ANCHO-1:0]     siguiente_c;
  logic [ANCHO-1:0]     primera_c;
  logic [ANCHO-1:0]     palabra_c;
  logic [RESP_W-1:0]    canales_c;

  paso_patron #(
    .ANCHO     (ANCHO),
    .CONSTANTE (CONSTANTE),
    .TOMAS     (TOMAS)
  ) u_paso (
    .modo        (modo_reg),
    .w           (base),
    .siguiente_c (siguiente_c)
  );

  // First word of a run, derived from the stored base
  always_comb begin
    primera_c = base;
    unique case (modo_reg)
      MODO_CONST: primera_c = CONSTANTE;
      MODO_RAMPA: primera_c = base;
      MODO_UNO:   primera_c = ANCHO'(1);
      MODO_LFSR:  primera_c = (base == '0) ? SEMILLA_LFSR : base;
      default:    primera_c = base;
    endcase
  end

  // Word about to be presented: first word when priming, else the stepped word
  always_comb begin
    palabra_c = siguiente_c;
    if (estado == CEBADO) palabra_c = primera_c;
  end

  // Per-channel offset: ramp adds the channel index, shifting modes rotate by it
  for (genvar i = 0; i < CANALES; i++) begin : g_canal
    localparam int unsigned DESP = i % ANCHO;
    logic [ANCHO-1:0] rot_c;
    if (DESP == 0) begin : g_sin_rot
      assign rot_c = palabra_c;
    end else begin : g_rot
      assign rot_c = {palabra_c[ANCHO-1-DESP:0], palabra_c[ANCHO-1:ANCHO-DESP]};
    end
    assign canales_c[i*ANCHO +: ANCHO] =
      (modo_reg == MODO_CONST) ? palabra_c :
      (modo_reg == MODO_RAMPA) ? palabra_c + ANCHO'(i) :
                                 rot_c;
  end

  // Control FSM with registered handshake, data and beat counter
  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      estado   <= REPOSO;
      modo_reg <= MODO_CONST;
      base     <= SEMILLA;
      cuenta_q <= '0;
      valido_q <= 1'b0;
      resp_q   <= '0;
    end else begin
      unique case (estado)
        REPOSO: begin
          if (bus.cargar) base <= bus.valor_carga;
          if (bus.habilitar) begin
            modo_reg <= bus.modo;
            estado   <= CEBADO;
          end
        end
        CEBADO: begin
          base     <= primera_c;
          resp_q   <= canales_c;
          valido_q <= 1'b1;
          estado   <= ACTIVO;
        end
        ACTIVO: begin
          if (bus.listo) begin
            base <= siguiente_c;
            if (cuenta_q != CUENTA_MAX) cuenta_q <= cuenta_q + CUENTA_W'(1);
            if (bus.habilitar) begin
              resp_q <= canales_c;
            end else begin
              valido_q <= 1'b0;
              estado   <= REPOSO;
            end
          end
        end
        default: begin
          valido_q <= 1'b0;
          estado   <= REPOSO;
        end
      endcase
    end
  end

  assign bus.valido       = valido_q;
  assign bus.respuesta    = resp_q;
  assign bus.cuenta_beats = cuenta_q;

endmodule
